// File: rtl/dmem_stream_ctrl.sv
// Streams a run of words from the combinational constant data memory onto a
// valid/ready stream, with start-of-frame and last markers.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | walking addresses, loading one word per free output slot
// DRAIN | final word loaded, waiting for it to be accepted
module dmem_stream_ctrl #(
  parameter int AW        = 9,
  parameter int DW        = 16,
  parameter int FRAME_LEN = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   count,
  input  logic          abort,
  output logic [AW-1:0] mem_a,
  input  logic [DW-1:0] mem_q,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  output logic          m_sof,
  output logic          m_last,
  input  logic          m_ready,
  output logic          busy,
  output logic          done
);

  localparam int IW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [AW:0]   REM_ONE  = (AW+1)'(1);
  localparam logic [IW-1:0] IDX_LAST = IW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [AW:0]   rem, rem_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic [AW-1:0] a_nxt;
  logic [DW-1:0] data_nxt;
  logic          valid_nxt, sof_nxt, last_nxt, done_nxt;
  logic          load;

  assign load = !m_valid || m_ready;
  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    a_nxt     = mem_a;
    rem_nxt   = rem;
    idx_nxt   = idx;
    valid_nxt = m_valid;
    data_nxt  = m_data;
    sof_nxt   = m_sof;
    last_nxt  = m_last;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            a_nxt     = base;
            rem_nxt   = count;
            idx_nxt   = '0;
            state_nxt = RUN;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      RUN: begin
        // A word loads whenever the output slot is empty or being emptied.
        if (load) begin
          data_nxt  = mem_q;
          valid_nxt = 1'b1;
          sof_nxt   = (idx == '0);
          last_nxt  = (rem == REM_ONE);
          a_nxt     = mem_a + 1'b1;
          rem_nxt   = rem - 1'b1;
          idx_nxt   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
          if (rem == REM_ONE) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (m_valid && m_ready) begin
          valid_nxt = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) begin
      state_nxt = IDLE;
      valid_nxt = 1'b0;
      done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mem_a   <= '0;
      rem     <= '0;
      idx     <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_sof   <= 1'b0;
      m_last  <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      mem_a   <= a_nxt;
      rem     <= rem_nxt;
      idx     <= idx_nxt;
      m_valid <= valid_nxt;
      m_data  <= data_nxt;
      m_sof   <= sof_nxt;
      m_last  <= last_nxt;
      done    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_dmem_stream_ctrl.sv
// Scoreboard bench for dmem_stream_ctrl: a small ROM model feeds mem_q, expected
// words are queued at start and compared as the stream delivers them.
module tb_dmem_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, abort, m_ready;
  logic [8:0]  base;
  logic [9:0]  count;
  logic [8:0]  mem_a;
  logic [15:0] mem_q;
  logic        m_valid, m_sof, m_last, busy, done;
  logic [15:0] m_data;

  dmem_stream_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .count(count),
    .abort(abort), .mem_a(mem_a), .mem_q(mem_q), .m_valid(m_valid),
    .m_data(m_data), .m_sof(m_sof), .m_last(m_last), .m_ready(m_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom(input logic [8:0] a);
    int k;
    k = int'(a) % 20;
    case (k)
      0:  return 16'h7FFF;  1:  return 16'h0C88;  2:  return 16'h1897;
      3:  return 16'h1446;  4:  return 16'h2A11;  5:  return 16'h3B22;
      6:  return 16'h4C33;  7:  return 16'h5D44;  8:  return 16'h6E55;
      9:  return 16'h8F66;  10: return 16'h0336;  11: return 16'hF378;
      12: return 16'hA1B2;  13: return 16'hC3D4;  14: return 16'hE5F6;
      15: return 16'h1357;  16: return 16'h2468;  17: return 16'h9ABC;
      18: return 16'hDEF0;  default: return 16'h0000;
    endcase
  endfunction

  assign mem_q = rom(mem_a);

  typedef struct {
    logic [15:0] d;
    logic        sof;
    logic        last;
    int          idx;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0, n_err = 0;
  int   cyc = 0, done_cnt = 0, done_cyc = 0, first_hs_cyc = 0, last_hs_cyc = 0;
  bit   rdy_rand = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rdy_rand) begin
      #1;
      m_ready = 1'($urandom_range(0, 1));
    end
  end

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (m_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", 32'(m_valid), 32'd0);
      end else begin
        chk("data", 32'(m_data), 32'(sb[0].d));
        chk("sof",  32'(m_sof),  32'(sb[0].sof));
        chk("last", 32'(m_last), 32'(sb[0].last));
        if (m_ready === 1'b1) begin
          if (sb[0].idx == 0) first_hs_cyc = cyc;
          if (sb[0].last) last_hs_cyc = cyc;
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int b, input int c);
    exp_t e;
    for (int i = 0; i < c; i++) begin
      e.d    = rom(9'((b + i) % 512));
      e.sof  = ((i % 20) == 0);
      e.last = (i == c - 1);
      e.idx  = i;
      sb.push_back(e);
    end
  endtask

  task automatic go(input int b, input int c);
    base  = 9'(b);
    count = 10'(c);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int i;
    i = 0;
    while ((busy !== 1'b0 || sb.size() != 0) && i < budget) begin
      tick();
      i++;
    end
    chk({tag, "_timeout"}, 32'(i >= budget), 32'd0);
    tick(2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int i;
    rst = 1'b1; start = 1'b0; abort = 1'b0; m_ready = 1'b1;
    base = '0; count = '0;
    tick(3);
    @(negedge clk);
    chk("rst_mem_a",   32'(mem_a),   32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data",  32'(m_data),  32'd0);
    chk("rst_m_sof",   32'(m_sof),   32'd0);
    chk("rst_m_last",  32'(m_last),  32'd0);
    chk("rst_busy",    32'(busy),    32'd0);
    chk("rst_done",    32'(done),    32'd0);
    tick();
    rst = 1'b0;
    tick(2);

    // basic stream, latency, throughput, done timing
    d0 = done_cnt;
    push_exp(0, 4);
    go(0, 4);
    @(negedge clk);
    chk("t1_lat_early", 32'(m_valid), 32'd0);
    chk("t1_busy",      32'(busy),    32'd1);
    @(negedge clk);
    chk("t1_lat_valid", 32'(m_valid), 32'd1);
    wait_idle(50, "t1");
    chk("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("t1_done_lat", 32'(done_cyc - last_hs_cyc), 32'd1);
    chk("t1_thruput",  32'(last_hs_cyc - first_hs_cyc), 32'd3);

    // address wrap
    d0 = done_cnt;
    push_exp(510, 4);
    go(510, 4);
    wait_idle(50, "t2");
    chk("t2_done_cnt", 32'(done_cnt - d0), 32'd1);

    // backpressure on the first word
    d0 = done_cnt;
    m_ready = 1'b0;
    push_exp(0, 3);
    go(0, 3);
    i = 0;
    @(negedge clk);
    while (m_valid !== 1'b1 && i < 10) begin
      @(negedge clk);
      i++;
    end
    chk("t3_valid_timeout", 32'(i >= 10), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t3_mem_a_hold", 32'(mem_a), 32'd1);
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    wait_idle(50, "t3");
    chk("t3_done_cnt", 32'(done_cnt - d0), 32'd1);

    // frame markers across two frames
    d0 = done_cnt;
    push_exp(0, 40);
    go(0, 40);
    wait_idle(200, "t4");
    chk("t4_done_cnt", 32'(done_cnt - d0), 32'd1);

    // zero count, then start while busy
    d0 = done_cnt;
    go(0, 0);
    @(negedge clk);
    chk("t5_zero_done",  32'(done),    32'd1);
    chk("t5_zero_busy",  32'(busy),    32'd0);
    chk("t5_zero_valid", 32'(m_valid), 32'd0);
    @(negedge clk);
    chk("t5_zero_pulse", 32'(done),    32'd0);
    tick();
    chk("t5_zero_cnt", 32'(done_cnt - d0), 32'd1);
    d0 = done_cnt;
    push_exp(3, 4);
    go(3, 4);
    tick();
    go(100, 5);
    wait_idle(50, "t5");
    chk("t5_busy_ign_cnt", 32'(done_cnt - d0), 32'd1);

    // full memory sweep under random backpressure
    d0 = done_cnt;
    rdy_rand = 1'b1;
    push_exp(5, 512);
    go(5, 512);
    wait_idle(3000, "t7");
    rdy_rand = 1'b0;
    tick();
    m_ready = 1'b1;
    chk("t7_done_cnt", 32'(done_cnt - d0), 32'd1);

    // abort mid-transfer, then a clean transfer
    d0 = done_cnt;
    push_exp(0, 10);
    go(0, 10);
    tick(3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("t6_abort_valid", 32'(m_valid), 32'd0);
    chk("t6_abort_busy",  32'(busy),    32'd0);
    tick(3);
    chk("t6_abort_done", 32'(done_cnt - d0), 32'd0);
    d0 = done_cnt;
    push_exp(20, 5);
    go(20, 5);
    wait_idle(50, "t6a");
    chk("t6a_done_cnt", 32'(done_cnt - d0), 32'd1);

    // reset mid-transfer, then a clean transfer
    d0 = done_cnt;
    push_exp(7, 10);
    go(7, 10);
    tick(3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("t6_rst_valid", 32'(m_valid), 32'd0);
    chk("t6_rst_busy",  32'(busy),    32'd0);
    chk("t6_rst_mem_a", 32'(mem_a),   32'd0);
    chk("t6_rst_data",  32'(m_data),  32'd0);
    tick(3);
    chk("t6_rst_done", 32'(done_cnt - d0), 32'd0);
    d0 = done_cnt;
    push_exp(509, 6);
    go(509, 6);
    wait_idle(50, "t6r");
    chk("t6r_done_cnt", 32'(done_cnt - d0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
